// File: rtl/bm_pkg.sv
// Shared definitions for the block-matching sub-pixel stage: flag encodings
// and the pipeline latency formula.
package bm_pkg;

   localparam logic [1:0] FLG_OK   = 2'b00;
   localparam logic [1:0] FLG_EDGE = 2'b01;
   localparam logic [1:0] FLG_FLAT = 2'b10;
   localparam logic [1:0] FLG_BAD  = 2'b11;

   // One input register, fw-1 divider stages, one output register.
   function automatic int bm_lat(input int fw);
      return fw + 1;
   endfunction

endpackage

// File: rtl/bm_div_pipe.sv
// Pipelined unsigned restoring divider: quo = floor(num * 2^QW / den), one
// quotient bit per stage. Assumes num < den for a meaningful result.
module bm_div_pipe #(
   parameter int NW = 16,
   parameter int DW = 18,
   parameter int QW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cke,
   input  logic          in_valid,
   input  logic [NW-1:0] num,
   input  logic [DW-1:0] den,
   output logic          out_valid,
   output logic [QW-1:0] quo
);

   logic [DW-1:0] rem_q [QW-1];
   logic [DW-1:0] den_q [QW-1];
   logic [QW-1:0] quo_q [QW];
   logic [QW-1:0] vld_q;

   logic [DW-1:0] cur_rem [QW];
   logic [DW-1:0] cur_den [QW];
   logic [QW-1:0] cur_quo [QW];
   logic [QW-1:0] cur_v;
   logic [DW-1:0] nxt_rem [QW];
   logic [QW-1:0] nxt_quo [QW];
   logic [QW-1:0] ge;
   logic [DW:0]   shl;
   logic [DW-1:0] dif;

   always_comb begin
      cur_rem[0] = DW'(num);
      cur_den[0] = den;
      cur_quo[0] = '0;
      cur_v[0]   = in_valid;
      for (int s = 1; s < QW; s++) begin
         cur_rem[s] = rem_q[s-1];
         cur_den[s] = den_q[s-1];
         cur_quo[s] = quo_q[s-1];
         cur_v[s]   = vld_q[s-1];
      end
      shl = '0;
      dif = '0;
      ge  = '0;
      for (int s = 0; s < QW; s++) begin
         shl        = {cur_rem[s], 1'b0};
         ge[s]      = (shl >= {1'b0, cur_den[s]});
         dif        = shl[DW-1:0] - cur_den[s];
         nxt_rem[s] = ge[s] ? dif : shl[DW-1:0];
         // Stage s decides quotient bit QW-1-s (MSB first).
         nxt_quo[s]          = cur_quo[s];
         nxt_quo[s][QW-1-s]  = ge[s];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < QW-1; s++) begin
            rem_q[s] <= '0;
            den_q[s] <= '0;
         end
         for (int s = 0; s < QW; s++) quo_q[s] <= '0;
         vld_q <= '0;
      end else if (cke) begin
         for (int s = 0; s < QW-1; s++) begin
            rem_q[s] <= nxt_rem[s];
            den_q[s] <= cur_den[s];
         end
         for (int s = 0; s < QW; s++) quo_q[s] <= nxt_quo[s];
         vld_q <= cur_v;
      end
   end

   assign out_valid = vld_q[QW-1];
   assign quo       = quo_q[QW-1];

endmodule

// File: rtl/bm_calc_subpix.sv
// Sub-pixel disparity refinement: fits an equiangular or parabolic curve
// through the costs around the winning index and emits a signed fraction.
module bm_calc_subpix
   import bm_pkg::*;
#(
   parameter int CW    = 16,
   parameter int IW    = 5,
   parameter int NDISP = 32,
   parameter int FW    = 8,
   parameter int TW    = 1
) (
   input  logic             rst_n,
   input  logic             clk,
   input  logic             cke,
   input  logic [CW-1:0]    det_min,
   input  logic [IW-1:0]    det_idx,
   input  logic [CW-1:0]    det_l,
   input  logic [CW-1:0]    det_r,
   input  logic             mode,
   input  logic [TW-1:0]    tag_in,
   input  logic             vin,
   output logic [FW-1:0]    frac_out,
   output logic [IW+FW-2:0] disp_out,
   output logic [1:0]       flag_out,
   output logic [TW-1:0]    tag_out,
   output logic             vout
);

   // Handshake: a sample is taken when vin=1 on a posedge with cke=1; there
   // is no backpressure. vout marks a result for exactly one cked cycle.
   localparam int QW = FW - 1;
   localparam int DW = CW + 2;
   localparam int XW = IW + FW - 1;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      logic          neg;
      logic [1:0]    flag;
   } sb_t;

   logic [CW:0]   n_val, mx_dif, sum_dif;
   logic [CW-1:0] n_abs, mx;
   logic [DW-1:0] den_c;
   logic          bad, at_edge;
   logic [1:0]    flag_c;

   always_comb begin
      n_val   = {1'b0, det_l} - {1'b0, det_r};
      n_abs   = n_val[CW] ? (det_r - det_l) : (det_l - det_r);
      mx      = (det_l > det_r) ? det_l : det_r;
      mx_dif  = {1'b0, mx} - {1'b0, det_min};
      sum_dif = {1'b0, det_l} + {1'b0, det_r} - {det_min, 1'b0};
      den_c   = mode ? {sum_dif, 1'b0} : {mx_dif, 1'b0};
      bad     = (det_l < det_min) || (det_r < det_min);
      at_edge = (det_idx == '0) || (det_idx == IW'(NDISP-1));
      if (at_edge)          flag_c = FLG_EDGE;
      else if (bad)         flag_c = FLG_BAD;
      else if (den_c == '0) flag_c = FLG_FLAT;
      else                  flag_c = FLG_OK;
   end

   logic          in_v;
   logic [CW-1:0] in_num;
   logic [DW-1:0] in_den;
   sb_t           in_sb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_v   <= 1'b0;
         in_num <= '0;
         in_den <= '0;
         in_sb  <= '0;
      end else if (cke) begin
         in_v <= vin;
         if (vin) begin
            // Flagged samples divide 0 so the divider never sees num >= den.
            in_num    <= (flag_c == FLG_OK) ? n_abs : '0;
            in_den    <= den_c;
            in_sb.idx  <= det_idx;
            in_sb.tag  <= tag_in;
            in_sb.neg  <= n_val[CW];
            in_sb.flag <= flag_c;
         end else begin
            in_num <= '0;
            in_den <= '0;
            in_sb  <= '0;
         end
      end
   end

   logic          div_v;
   logic [QW-1:0] div_q;

   bm_div_pipe #(.NW(CW), .DW(DW), .QW(QW)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .cke      (cke),
      .in_valid (in_v),
      .num      (in_num),
      .den      (in_den),
      .out_valid(div_v),
      .quo      (div_q)
   );

   sb_t sb_q [QW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < QW; k++) sb_q[k] <= '0;
      end else if (cke) begin
         sb_q[0] <= in_sb;
         for (int k = 1; k < QW; k++) sb_q[k] <= sb_q[k-1];
      end
   end

   sb_t           sb_last;
   logic [FW-1:0] qx, fr_c;
   logic [XW-1:0] disp_c;

   always_comb begin
      sb_last = sb_q[QW-1];
      qx      = {1'b0, div_q};
      fr_c    = '0;
      if (sb_last.flag == FLG_OK) fr_c = sb_last.neg ? (FW'(0) - qx) : qx;
      disp_c  = {sb_last.idx, {QW{1'b0}}} + {{(IW-1){fr_c[FW-1]}}, fr_c};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vout     <= 1'b0;
         frac_out <= '0;
         disp_out <= '0;
         flag_out <= '0;
         tag_out  <= '0;
      end else if (cke) begin
         vout <= div_v;
         if (div_v) begin
            frac_out <= fr_c;
            disp_out <= disp_c;
            flag_out <= sb_last.flag;
            tag_out  <= sb_last.tag;
         end else begin
            frac_out <= '0;
            disp_out <= '0;
            flag_out <= '0;
            tag_out  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bm_calc_subpix.sv
// Self-checking bench for bm_calc_subpix: directed fits, randomized stream
// with cke stalls against an arithmetic reference model, and reset flush.
module tb_bm_calc_subpix;
   import bm_pkg::*;

   localparam int CW = 16, IW = 5, NDISP = 32, FW = 8, TW = 1;
   localparam int LAT = bm_lat(FW);
   localparam int XW = IW + FW - 1;
   localparam int EW = TW + 2 + XW + FW;

   logic             clk, rst_n, cke, mode, vin, vout;
   logic [CW-1:0]    det_min, det_l, det_r;
   logic [IW-1:0]    det_idx;
   logic [TW-1:0]    tag_in, tag_out;
   logic [FW-1:0]    frac_out;
   logic [XW-1:0]    disp_out;
   logic [1:0]       flag_out;

   int n_cmp = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   bm_calc_subpix #(.CW(CW), .IW(IW), .NDISP(NDISP), .FW(FW), .TW(TW)) dut (
      .rst_n   (rst_n),
      .clk     (clk),
      .cke     (cke),
      .det_min (det_min),
      .det_idx (det_idx),
      .det_l   (det_l),
      .det_r   (det_r),
      .mode    (mode),
      .tag_in  (tag_in),
      .vin     (vin),
      .frac_out(frac_out),
      .disp_out(disp_out),
      .flag_out(flag_out),
      .tag_out (tag_out),
      .vout    (vout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: fraction of the fitted minimum, straight from the formulas.
   function automatic logic [EW-1:0] ref_model(int l, int c, int r, int idx, int md, int tag);
      int n, d, mag, fr, fl, disp;
      n  = l - r;
      d  = md ? 2 * (l + r - 2 * c) : 2 * (((l > r) ? l : r) - c);
      fl = 0;
      fr = 0;
      if (idx == 0 || idx == NDISP - 1) fl = 1;
      else if (l < c || r < c)          fl = 3;
      else if (d == 0)                  fl = 2;
      else begin
         mag = ((n < 0 ? -n : n) * (1 << (FW - 1))) / d;
         fr  = (n < 0) ? -mag : mag;
      end
      disp = idx * (1 << (FW - 1)) + fr;
      return {TW'(tag), 2'(fl), XW'(disp), FW'(fr)};
   endfunction

   function automatic logic [EW-1:0] observed();
      return {tag_out, flag_out, disp_out, frac_out};
   endfunction

   // driver
   task automatic drive(int l, int c, int r, int idx, int md, int tag, bit v);
      det_l   = CW'(l);
      det_min = CW'(c);
      det_r   = CW'(r);
      det_idx = IW'(idx);
      mode    = md[0];
      tag_in  = TW'(tag);
      vin     = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cke   = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({vout, observed()} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got vout=%b out=%h, want all 0", vout, observed());
      end
      rst_n = 1'b1;
      cke   = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single(string name, int l, int c, int r, int idx, int md);
      logic [EW-1:0] exp_w;
      bit got;
      int tag;
      tag   = $urandom_range(0, 1);
      exp_w = ref_model(l, c, r, idx, md, tag);
      got   = 1'b0;
      cke   = 1'b1;
      drive(l, c, r, idx, md, tag, 1'b1);
      for (int i = 1; i <= 3 * LAT; i++) begin
         @(negedge clk);
         if (i == 1) vin = 1'b0;
         if (vout) begin
            got = 1'b1;
            n_cmp++;
            if (i != LAT) begin
               n_err++;
               $display("FAIL %s_latency: got %0d cycles, want %0d", name, i, LAT);
            end
            n_cmp++;
            if (observed() !== exp_w) begin
               n_err++;
               $display("FAIL %s_result: got tag/flag/disp/frac=%h, want %h", name, observed(), exp_w);
            end
            break;
         end else begin
            n_cmp++;
            if (observed() !== '0) begin
               n_err++;
               $display("FAIL %s_idle_zero: got %h with vout=0, want 0", name, observed());
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: no vout within %0d cycles, want one at %0d", name, 3 * LAT, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      test_single("mode0_fit",  30, 10, 20, 5, 0);
      test_single("mode1_fit",  30, 10, 20, 5, 1);
      test_single("mode1_swap", 20, 10, 30, 5, 1);
      test_single("edge_idx0",  30, 10, 20, 0, 0);
      test_single("edge_top",   30, 10, 20, NDISP - 1, 1);
      test_single("flat",        7,  7,  7, 4, 0);
      test_single("bad",         5, 10, 20, 7, 1);
   endtask

   task automatic test_back_to_back();
      int sent, recv, l, c, r, idx, md, tag, kind;
      logic [EW-1:0] exp_w;
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 400 && recv < 32; cyc++) begin
         // cke still holds the value seen at the edge just passed
         if (cke && vout) begin
            recv++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL b2b_unexpected: got %h, want nothing", observed());
            end else begin
               exp_w = exp_q.pop_front();
               if (observed() !== exp_w) begin
                  n_err++;
                  $display("FAIL b2b_result: got %h, want %h", observed(), exp_w);
               end
            end
         end
         cke  = ($urandom_range(0, 99) >= 30);
         c    = $urandom_range(0, 2000);
         l    = c + $urandom_range(0, 600);
         r    = c + $urandom_range(0, 600);
         idx  = $urandom_range(1, NDISP - 2);
         md   = $urandom_range(0, 1);
         tag  = $urandom_range(0, 1);
         kind = $urandom_range(0, 9);
         if (kind == 0 && c > 0) l = c - $urandom_range(1, c);
         if (kind == 1) begin l = c; r = c; end
         if (kind == 2) idx = $urandom_range(0, 1) ? NDISP - 1 : 0;
         drive(l, c, r, idx, md, tag, (sent < 32) && ($urandom_range(0, 99) >= 15));
         if (cke && vin) begin
            exp_q.push_back(ref_model(l, c, r, idx, md, tag));
            sent++;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (recv != 32 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_count: got %0d results (%0d pending), want 32", recv, exp_q.size());
      end
      exp_q.delete();
      cke = 1'b1;
      vin = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      cke = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(30 + i, 10, 20, 5 + i, i % 2, i % 2, 1'b1);
         @(negedge clk);
      end
      vin   = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({vout, observed()} !== '0) begin
         n_err++;
         $display("FAIL rst_async_clear: got vout=%b out=%h, want all 0", vout, observed());
      end
      @(negedge clk);
      n_cmp++;
      if ({vout, observed()} !== '0) begin
         n_err++;
         $display("FAIL rst_held_clear: got vout=%b out=%h, want all 0", vout, observed());
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         n_cmp++;
         if (vout !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flush: got vout=%b at cycle %0d after reset, want 0", vout, i + 1);
         end
      end
      test_single("post_reset", 40, 12, 25, 9, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bm_calc_subpix.md
BM_CALC_SUBPIX -- requirements
Module: bm_calc_subpix

Interface
REQ-001 SHALL have parameter CW, default 16: cost width in bits.
REQ-002 SHALL have parameter IW, default 5: disparity index width in bits.
REQ-003 SHALL have parameter NDISP, default 32: number of disparity candidates, at most 2^IW.
REQ-004 SHALL have parameter FW, default 8: signed fraction width; the LSB weighs 2^-(FW-1).
REQ-005 SHALL have parameter TW, default 1: sideband tag width.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-008 SHALL have port cke, input, 1 bit: pipeline enable; when low, the whole pipeline holds.
REQ-009 SHALL have port det_min, input, CW bits: cost C at the winning index.
REQ-010 SHALL have port det_idx, input, IW bits: winning index.
REQ-011 SHALL have ports det_l and det_r, input, CW bits each: costs at idx-1 and idx+1.
REQ-012 SHALL have port mode, input, 1 bit: 0 selects the equiangular fit, 1 selects the parabola fit; sampled per sample.
REQ-013 SHALL have port tag_in, input, TW bits: sideband carried alongside the sample.
REQ-014 SHALL have port vin, input, 1 bit: sample valid, qualified by cke.
REQ-015 SHALL have port frac_out, output, FW bits: signed fraction.
REQ-016 SHALL have port disp_out, output, IW+FW-1 bits: unsigned disparity, equal to idx*2^(FW-1)+frac.
REQ-017 SHALL have port flag_out, output, 2 bits: 00 ok, 01 edge, 10 flat, 11 bad.
REQ-018 SHALL have port tag_out, output, TW bits: sideband aligned with vout.
REQ-019 SHALL have port vout, output, 1 bit: output valid.

Function
REQ-020 SHALL compute N = det_l - det_r as signed (CW+1) bits, and D = 2*(max(L,R)-C) in mode 0 or D = 2*(L+R-2C) in mode 1, unsigned CW+2 bits.
REQ-021 SHALL compute frac = sign(N) * trunc(|N|/D * 2^(FW-1)): magnitude truncated toward zero, then negated if N<0; the result always lies in [-2^(FW-2), +2^(FW-2)].
REQ-022 SHALL set flag bad when L<C or R<C, with frac=0.
REQ-023 SHALL set flag edge when idx==0 or idx==NDISP-1, with frac=0; edge takes priority over bad.
REQ-024 SHALL set flag flat when D==0 and neither edge nor bad applies, with frac=0.
REQ-025 SHALL treat positive frac as a shift toward idx+1; disp_out = {idx, zeros} + sign-extended frac, and disp_out shall not underflow given REQ-023.
REQ-026 SHALL have latency LAT = FW+1 cked cycles from vin to vout: one input register, FW-1 divider stages, one output register.
REQ-027 SHALL accept back-to-back samples at throughput 1 per cked cycle, with vin gaps allowed.
REQ-028 SHALL, when cke=0, hold all pipeline registers and outputs and not advance vout.
REQ-029 SHALL give frac_out, disp_out, flag_out and tag_out the value 0 whenever vout=0.
REQ-030 SHALL carry mode, flags and tag through the pipeline with each sample, so a mode change between adjacent samples is honoured per sample.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear every register, making all outputs 0 and vout 0.
REQ-032 SHALL discard all in-flight samples on reset mid-stream; the first vout after release comes exactly LAT cked cycles after the first post-reset vin.

Structure
REQ-033 SHALL use sub-module bm_div_pipe(NW, DW, QW): an unsigned restoring divider, one quotient bit per stage, with valid and cke ports.
REQ-034 SHALL place the flag encodings (FLG_OK, FLG_EDGE, FLG_FLAT, FLG_BAD) and the latency formula in shared package bm_pkg.

Verification
REQ-035 SHALL test FW=8, mode0, L=30, C=10, R=20, idx=5 -> frac=0x20, disp=672, flag=00 after 9 cycles.
REQ-036 SHALL test the same costs in mode1 -> frac=0x15 (21), disp=661; swapping L and R -> frac=0xEB (-21), disp=619.
REQ-037 SHALL test idx=0 -> flag=01, frac=0; all costs 7 at idx=4 -> flag=10, disp=512; L=5, C=10 -> flag=11.
REQ-038 SHALL test 32 back-to-back samples with random modes and cke toggling 30% low -> outputs in order, tags preserved, bit-exact against a reference model.
REQ-039 SHALL test rst_n pulsed low with 4 samples in flight -> no vout for those samples, and all outputs 0 during reset.
